// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front end: pixel and column
// types, the kernel position flags and the column generator state encoding.
package conv_pkg;

    localparam int KERNEL_DIAMETER_N = 5;
    localparam int PIXEL_W           = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Index 0 is the oldest row, index KERNEL_DIAMETER_N-1 the current row.
    typedef pixel_t [KERNEL_DIAMETER_N-1:0] pixel_span_t;

    typedef struct packed {
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } kernel_pos_t;

    typedef enum logic [1:0] {
        PRIME,
        STREAM,
        FLUSH
    } col_gen_state_t;

endpackage

// File: rtl/conv_line_buf.sv
// One row of pixel storage. Reads are asynchronous, so a read and a write to
// the same address in one cycle return the old contents.
module conv_line_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdat,
    output logic [W-1:0]             rdat
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdat;
        end
    end

    assign rdat = mem[addr];

endmodule

// File: rtl/conv_col_gen.sv
// Turns a raster pixel stream into vertical kernel columns, priming the line
// buffers at frame start and inserting flush columns after every streamed row.
module conv_col_gen
    import conv_pkg::*;
#(
    parameter int IMAGE_W = 64,
    parameter int IMAGE_H = 64,
    parameter int FLUSH_N = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_vld_i,
    output logic                         pix_rdy_o,
    input  logic [PIXEL_W-1:0]           pix_dat_i,
    input  logic                         pix_sof_i,
    output logic                         colD_vld_o,
    output logic [KERNEL_DIAMETER_N-1:0] colD_push_o,
    output pixel_span_t                  colD_dat_o,
    output kernel_pos_t                  colD_pos_o
);

    localparam int LB_N = KERNEL_DIAMETER_N - 1;
    localparam int XW   = $clog2(IMAGE_W);
    localparam int YW   = $clog2(IMAGE_H);
    localparam int FW   = $clog2(FLUSH_N + 1);

    localparam logic [XW-1:0] X_LAST         = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST         = YW'(IMAGE_H - 1);
    localparam logic [YW-1:0] Y_PRIME_LAST   = YW'(KERNEL_DIAMETER_N - 2);
    localparam logic [YW-1:0] Y_FIRST_STREAM = YW'(KERNEL_DIAMETER_N - 1);
    localparam logic [FW-1:0] F_LAST         = FW'(FLUSH_N - 1);

    col_gen_state_t                 state_q, state_d;
    logic [XW-1:0]                  x_q, x_d;
    logic [YW-1:0]                  y_q, y_d;
    logic [FW-1:0]                  flush_q, flush_d;
    logic                           vld_q, vld_d;
    logic [KERNEL_DIAMETER_N-1:0]   push_q, push_d;
    pixel_span_t                    dat_q, dat_d;
    kernel_pos_t                    pos_q, pos_d;

    logic          accept;
    logic          resync;
    logic          xLast;
    logic [XW-1:0] bufAddr;
    pixel_t        lbRd [LB_N];
    pixel_t        lbWr [LB_N];
    pixel_span_t   column;

    // Ready also drops while a flush column is on the outputs, so the input
    // never restarts before the last flush column has been seen downstream.
    assign pix_rdy_o = !rst && (state_q != FLUSH) && !(push_q[0] && !vld_q);
    assign accept    = pix_vld_i && pix_rdy_o;
    assign resync    = accept && pix_sof_i && ((x_q != '0) || (y_q != '0));
    assign xLast     = (x_q == X_LAST);
    assign bufAddr   = resync ? '0 : x_q;

    for (genvar n = 0; n < LB_N; n++) begin : gLineBuf
        if (n == LB_N - 1) begin : gTop
            assign lbWr[n] = pix_dat_i;
        end else begin : gChain
            assign lbWr[n] = lbRd[n+1];
        end

        conv_line_buf #(
            .W     (PIXEL_W),
            .DEPTH (IMAGE_W)
        ) uLineBuf (
            .clk   (clk),
            .wr_en (accept),
            .addr  (bufAddr),
            .wdat  (lbWr[n]),
            .rdat  (lbRd[n])
        );
    end

    always_comb begin
        column = '0;
        for (int n = 0; n < LB_N; n++) begin
            column[n] = lbRd[n];
        end
        column[KERNEL_DIAMETER_N-1] = pix_dat_i;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        flush_d = flush_q;
        push_d  = '0;
        vld_d   = 1'b0;
        dat_d   = dat_q;
        pos_d   = pos_q;

        if (accept) begin
            if (xLast) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // A mid-frame start-of-frame pixel becomes pixel (0,0) of a new frame.
        if (resync) begin
            state_d = PRIME;
            x_d     = XW'(1);
            y_d     = '0;
            flush_d = '0;
        end else begin
            unique case (state_q)
                PRIME: begin
                    if (accept && xLast && (y_q == Y_PRIME_LAST)) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        push_d    = '1;
                        vld_d     = 1'b1;
                        dat_d     = column;
                        pos_d.sof = (x_q == '0) && (y_q == Y_FIRST_STREAM);
                        pos_d.sol = (x_q == '0);
                        pos_d.eol = xLast;
                        pos_d.eof = xLast && (y_q == Y_LAST);
                        if (xLast) begin
                            state_d = FLUSH;
                            flush_d = '0;
                        end
                    end
                end
                FLUSH: begin
                    push_d = '1;
                    dat_d  = '0;
                    pos_d  = '0;
                    if (flush_q == F_LAST) begin
                        flush_d = '0;
                        state_d = (y_q == '0) ? PRIME : STREAM;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRIME;
            x_q     <= '0;
            y_q     <= '0;
            flush_q <= '0;
            vld_q   <= 1'b0;
            push_q  <= '0;
            dat_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            flush_q <= flush_d;
            vld_q   <= vld_d;
            push_q  <= push_d;
            dat_q   <= dat_d;
            pos_q   <= pos_d;
        end
    end

    assign colD_vld_o  = vld_q;
    assign colD_push_o = push_q;
    assign colD_dat_o  = dat_q;
    assign colD_pos_o  = pos_q;

endmodule

// File: tb/tb_conv_col_gen.sv
// Bench for conv_col_gen on an 8x8 image: a frame-row reference model predicts
// every output cycle, with directed checks on frame boundaries and recovery.
module tb_conv_col_gen;
    import conv_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int FL_N  = 2;
    localparam int N     = KERNEL_DIAMETER_N;

    typedef struct packed {
        logic        vld;
        pixel_span_t dat;
        kernel_pos_t pos;
    } expCol_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_vld_i = 1'b0;
    logic          pix_rdy_o;
    pixel_t        pix_dat_i = '0;
    logic          pix_sof_i = 1'b0;
    logic          colD_vld_o;
    logic [N-1:0]  colD_push_o;
    pixel_span_t   colD_dat_o;
    kernel_pos_t   colD_pos_o;

    expCol_t     expQ [$];
    pixel_t      rowMem [IMG_H][IMG_W];
    int          mx = 0;
    int          my = 0;
    int          vecCount = 0;
    int          errCount = 0;
    logic        lastAccepted = 1'b0;
    logic        afterReset = 1'b0;
    logic        resyncDone;
    pixel_span_t lastDat = '0;

    conv_col_gen #(
        .IMAGE_W (IMG_W),
        .IMAGE_H (IMG_H),
        .FLUSH_N (FL_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_vld_i   (pix_vld_i),
        .pix_rdy_o   (pix_rdy_o),
        .pix_dat_i   (pix_dat_i),
        .pix_sof_i   (pix_sof_i),
        .colD_vld_o  (colD_vld_o),
        .colD_push_o (colD_push_o),
        .colD_dat_o  (colD_dat_o),
        .colD_pos_o  (colD_pos_o)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame-coordinate model: a streamed pixel at (x,y) sees rows y-4..y-1 at x.
    task automatic modelAccept(input pixel_t d, input logic s);
        expCol_t e;
        if (s && (mx != 0 || my != 0)) begin
            rowMem[0][0] = d;
            mx = 1;
            my = 0;
            return;
        end
        if (my >= N - 1) begin
            e = '0;
            e.vld = 1'b1;
            for (int n = 0; n < N - 1; n++) e.dat[n] = rowMem[my-(N-1)+n][mx];
            e.dat[N-1] = d;
            e.pos.sof = (mx == 0) && (my == N - 1);
            e.pos.sol = (mx == 0);
            e.pos.eol = (mx == IMG_W - 1);
            e.pos.eof = (mx == IMG_W - 1) && (my == IMG_H - 1);
            expQ.push_back(e);
            if (mx == IMG_W - 1) begin
                for (int k = 0; k < FL_N; k++) expQ.push_back('0);
            end
        end
        rowMem[my][mx] = d;
        if (mx == IMG_W - 1) begin
            mx = 0;
            my = (my == IMG_H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic checkOutput(input logic wasReset);
        expCol_t e;
        if (wasReset) begin
            checkVal("resetPush", colD_push_o, 0);
            checkVal("resetVld", colD_vld_o, 0);
            checkVal("resetDat", colD_dat_o, 0);
            checkVal("resetPos", colD_pos_o, 0);
        end else if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal("colPush", colD_push_o, {N{1'b1}});
            checkVal("colVld", colD_vld_o, e.vld);
            checkVal("colDat", colD_dat_o, e.dat);
            checkVal("colPos", colD_pos_o, e.pos);
            if (!e.vld) checkVal("flushRdy", pix_rdy_o, 0);
        end else begin
            checkVal("idlePush", colD_push_o, 0);
            checkVal("idleVld", colD_vld_o, 0);
            checkVal("holdDat", colD_dat_o, lastDat);
        end
        lastDat = colD_dat_o;
    endtask

    task automatic applyStimulus(input logic r, input logic v, input pixel_t d, input logic s);
        rst       = r;
        pix_vld_i = v;
        pix_dat_i = d;
        pix_sof_i = s;
        #1;
        if (r) checkVal("rdyInReset", pix_rdy_o, 0);
        else if (afterReset) checkVal("rdyAfterReset", pix_rdy_o, 1);
        afterReset   = r;
        lastAccepted = !r && v && pix_rdy_o;
        if (r) begin
            expQ.delete();
            mx = 0;
            my = 0;
        end else if (lastAccepted) begin
            modelAccept(d, s);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput(r);
    endtask

    task automatic feedPixels(input int count, input int gapPct, input bit randData, input logic [7:0] offset);
        int     acc = 0;
        int     cyc = 0;
        logic   v;
        pixel_t d;
        while (acc < count && cyc < count * 8 + 64) begin
            v = ($urandom_range(0, 99) >= gapPct);
            d = randData ? pixel_t'($urandom) : pixel_t'(int'(offset) + 16 * my + mx);
            applyStimulus(1'b0, v, d, (mx == 0 && my == 0));
            if (lastAccepted) acc++;
            cyc++;
        end
        checkVal("feedBudget", acc, count);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);

        // Frame A: first streamed column and end-of-frame column.
        feedPixels(33, 0, 1'b0, 8'h00);
        checkVal("firstColDat", colD_dat_o, 40'h40_30_20_10_00);
        checkVal("firstColPos", colD_pos_o, 4'b1010);
        feedPixels(31, 0, 1'b0, 8'h00);
        checkVal("eofColPos", colD_pos_o, 4'b0101);
        checkVal("eofColPix", colD_dat_o[N-1], 8'h77);

        // Frame B back-to-back with a distinct offset.
        feedPixels(33, 0, 1'b0, 8'h80);
        checkVal("frameBFirstDat", colD_dat_o, 40'hC0_B0_A0_90_80);
        feedPixels(31, 0, 1'b0, 8'h80);

        feedPixels(64, 50, 1'b1, 8'h00);
        feedPixels(64, 50, 1'b0, 8'h20);

        // Start-of-frame resync at (3,6).
        feedPixels(51, 0, 1'b0, 8'h00);
        resyncDone = 1'b0;
        for (int i = 0; i < 20 && !resyncDone; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
            resyncDone = lastAccepted;
        end
        checkVal("resyncAccepted", resyncDone, 1);
        feedPixels(39, 0, 1'b0, 8'h00);
        checkVal("resyncEolPos", colD_pos_o, 4'b0001);
        checkVal("resyncEolPix", colD_dat_o[N-1], 8'h47);
        feedPixels(24, 0, 1'b0, 8'h00);

        // Reset on the first flush cycle, then a fresh frame.
        feedPixels(40, 0, 1'b0, 8'h10);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        feedPixels(33, 0, 1'b0, 8'h00);
        checkVal("postResetDat", colD_dat_o, 40'h40_30_20_10_00);
        checkVal("postResetPos", colD_pos_o, 4'b1010);
        feedPixels(31, 0, 1'b0, 8'h00);

        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkVal("queueDrained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
